instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit feeding the IF/ID register, with stall, jump and branch redirect.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jOnlyPCsrc,
  input  logic [31:0] jNextPC,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic        inst_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} fetchStateT;

  fetchStateT  state;
  logic [31:0] pc;
  logic [31:0] reqPc;
  logic [31:0] bufInst;
  logic [31:0] bufPc;

  logic        redirect;
  logic [31:0] redirectPc;
  logic        accept;
  logic        loadWait;
  logic        loadHold;
  logic        load;
  logic [31:0] newInst;
  logic [31:0] newPc;

  // A branch resolved in MEM is older than a jump decoded in ID, so it wins.
  assign redirect   = branch_taken | jOnlyPCsrc;
  assign redirectPc = branch_taken ? branch_target : jNextPC;

  assign imem_req  = (state == IDLE) && !redirect && !rst;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  assign loadWait = (state == WAIT) && imem_rvalid && !stall && !redirect;
  assign loadHold = (state == HOLD) && !stall && !redirect;
  assign load     = loadWait || loadHold;
  assign newInst  = loadHold ? bufInst : imem_rdata;
  assign newPc    = loadHold ? bufPc   : reqPc;

  // NOTE: every register here, including the one-entry buffer, is reset so no X ever reaches decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      reqPc      <= 32'h0;
      bufInst    <= 32'h0;
      bufPc      <= 32'h0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      if (redirect)    pc <= redirectPc;
      else if (accept) pc <= pc + 32'd4;

      if (accept) reqPc <= pc;

      unique case (state)
        IDLE: if (accept) state <= WAIT;
        WAIT: begin
          if (redirect) begin
            // A response arriving with the redirect is simply dropped; otherwise it is still in flight.
            state <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            if (stall) begin
              bufInst <= imem_rdata;
              bufPc   <= reqPc;
              state   <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: if (imem_rvalid) state <= IDLE;
        HOLD: if (redirect || !stall) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (branch_taken) begin
        inst_valid <= 1'b0;
      end else if (load) begin
        inst       <= newInst;
        inst_pc    <= newPc;
        inst_valid <= 1'b1;
      end else if (!stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      if (!stall && !load) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Table-driven bench for instruction_fetch plus hand sequences for PC wrap and reset mid-fetch.
// Counter checks are compiled in when IFETCH_PERF_EN is defined.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jOnlyPCsrc;
  logic [31:0] jNextPC;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .jOnlyPCsrc   (jOnlyPCsrc),
    .jNextPC      (jNextPC),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .inst         (inst),
    .inst_pc      (inst_pc),
`ifdef IFETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles),
`endif
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        jmp;
    logic [31:0] jpc;
    logic        br;
    logic [31:0] btgt;
    logic        eReq;
    logic [31:0] eAddr;
    logic [31:0] eInst;
    logic [31:0] ePc;
    logic        eValid;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic v, input logic [31:0] d,
                     input logic j, input logic [31:0] jp, input logic b, input logic [31:0] bt,
                     input logic eq, input logic [31:0] ea, input logic [31:0] ei,
                     input logic [31:0] ep, input logic ev);
    vecs.push_back('{s, r, v, d, j, jp, b, bt, eq, ea, ei, ep, ev});
  endtask

  task automatic idleInputs();
    stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    jOnlyPCsrc = 1'b0; jNextPC = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  initial begin
    // stall ready rvalid rdata | jmp jpc | br btgt || req addr(before edge) | inst inst_pc valid (after edge)
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h0  , 32'h0       ,32'h0  ,0);
    add(0,0,1,32'h11111111, 0,32'h0  , 0,32'h0  , 0,32'h4  , 32'h11111111,32'h0  ,1);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h4  , 32'h11111111,32'h0  ,0);
    add(0,0,1,32'h22222222, 0,32'h0  , 0,32'h0  , 0,32'h8  , 32'h22222222,32'h4  ,1);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h8  , 32'h22222222,32'h4  ,0);
    // word for 8 returns under a 3-cycle stall, then released
    add(1,0,1,32'h8C010004, 0,32'h0  , 0,32'h0  , 0,32'hC  , 32'h22222222,32'h4  ,0);
    add(1,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 0,32'hC  , 32'h22222222,32'h4  ,0);
    add(1,0,0,32'h0       , 0,32'h0  , 0,32'h0  , 0,32'hC  , 32'h22222222,32'h4  ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 0,32'hC  , 32'h8C010004,32'h8  ,1);
    // jump back to 8, then jump to 0x40 while the fetch of 8 is outstanding
    add(0,0,0,32'h0       , 1,32'h8  , 0,32'h0  , 0,32'hC  , 32'h8C010004,32'h8  ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h8  , 32'h8C010004,32'h8  ,0);
    add(0,0,0,32'h0       , 1,32'h40 , 0,32'h0  , 0,32'hC  , 32'h8C010004,32'h8  ,0);
    add(0,0,1,32'h33333333, 0,32'h0  , 0,32'h0  , 0,32'h40 , 32'h8C010004,32'h8  ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h40 , 32'h8C010004,32'h8  ,0);
    add(0,0,1,32'h44444444, 0,32'h0  , 0,32'h0  , 0,32'h44 , 32'h44444444,32'h40 ,1);
    // redirect in the same cycle as the response
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h44 , 32'h44444444,32'h40 ,0);
    add(0,0,1,32'h55555555, 1,32'h80 , 0,32'h0  , 0,32'h48 , 32'h44444444,32'h40 ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h80 , 32'h44444444,32'h40 ,0);
    add(0,0,1,32'h66666666, 0,32'h0  , 0,32'h0  , 0,32'h84 , 32'h66666666,32'h80 ,1);
    // branch and jump together under stall: branch wins, valid cleared
    add(1,1,0,32'h0       , 1,32'h40 , 1,32'h100, 0,32'h84 , 32'h66666666,32'h80 ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h100, 32'h66666666,32'h80 ,0);
    // branch while holding a buffered word
    add(1,0,1,32'h77777777, 0,32'h0  , 0,32'h0  , 0,32'h104, 32'h66666666,32'h80 ,0);
    add(1,0,0,32'h0       , 0,32'h0  , 1,32'h200, 0,32'h104, 32'h66666666,32'h80 ,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h200, 32'h66666666,32'h80 ,0);
    add(0,0,1,32'h88888888, 0,32'h0  , 0,32'h0  , 0,32'h204, 32'h88888888,32'h200,1);
    // stray rvalid in IDLE is ignored
    add(0,0,1,32'h99999999, 0,32'h0  , 0,32'h0  , 1,32'h204, 32'h88888888,32'h200,0);
    // redirects while in DROP
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h204, 32'h88888888,32'h200,0);
    add(0,0,0,32'h0       , 1,32'h300, 0,32'h0  , 0,32'h208, 32'h88888888,32'h200,0);
    add(0,0,0,32'h0       , 1,32'h400, 0,32'h0  , 0,32'h300, 32'h88888888,32'h200,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 0,32'h400, 32'h88888888,32'h200,0);
    add(0,0,1,32'hAAAAAAAA, 0,32'h0  , 0,32'h0  , 0,32'h400, 32'h88888888,32'h200,0);
    add(0,1,0,32'h0       , 0,32'h0  , 0,32'h0  , 1,32'h400, 32'h88888888,32'h200,0);
    add(0,0,1,32'hBBBBBBBB, 0,32'h0  , 0,32'h0  , 0,32'h404, 32'hBBBBBBBB,32'h400,1);

    idleInputs();
    rst = 1'b1;
    #1;
    check("reset_req", {31'h0, imem_req}, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_inst", inst, 32'h0);
    check("reset_inst_pc", inst_pc, 32'h0);
    check("reset_valid", {31'h0, inst_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; imem_ready = vecs[i].ready; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; jOnlyPCsrc = vecs[i].jmp; jNextPC = vecs[i].jpc;
      branch_taken = vecs[i].br; branch_target = vecs[i].btgt;
      #1;
      check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].eReq});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].eAddr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_inst", i), inst, vecs[i].eInst);
      check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].ePc);
      check($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].eValid});
      @(negedge clk);
    end
`ifdef IFETCH_PERF_EN
    check("perf_fetched_table", perf_fetched, 32'd7);
    check("perf_bubbles_table", perf_bubbles, 32'd20);
`endif

    // PC wrap: fetch at FFFF_FFFC, next address is 0
    idleInputs();
    jOnlyPCsrc = 1'b1; jNextPC = 32'hFFFF_FFFC;
    @(negedge clk);
    idleInputs();
    imem_ready = 1'b1;
    #1;
    check("wrap_req", {31'h0, imem_req}, 32'h1);
    check("wrap_addr_before", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr_after", imem_addr, 32'h0);
    idleInputs();
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("wrap_inst", inst, 32'hCAFE_F00D);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_valid", {31'h0, inst_valid}, 32'h1);

    // Reset pulsed while a fetch is outstanding; the late response must be ignored
    idleInputs();
    jOnlyPCsrc = 1'b1; jNextPC = 32'h0000_0500;
    @(negedge clk);
    idleInputs();
    imem_ready = 1'b1;
    @(negedge clk);
    check("pre_reset_addr", imem_addr, 32'h504);
    idleInputs();
    rst = 1'b1;
    #1;
    check("async_reset_addr", imem_addr, 32'h0);
    check("async_reset_req", {31'h0, imem_req}, 32'h0);
    check("async_reset_valid", {31'h0, inst_valid}, 32'h0);
    check("async_reset_inst", inst, 32'h0);
`ifdef IFETCH_PERF_EN
    check("perf_fetched_reset", perf_fetched, 32'h0);
    check("perf_bubbles_reset", perf_bubbles, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("stale_req", {31'h0, imem_req}, 32'h1);
    @(negedge clk);
    check("stale_valid", {31'h0, inst_valid}, 32'h0);
    check("stale_inst", inst, 32'h0);
    check("stale_addr", imem_addr, 32'h0);
    idleInputs();
    imem_ready = 1'b1;
    @(negedge clk);
    check("restart_addr", imem_addr, 32'h4);
    idleInputs();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("restart_inst", inst, 32'h1234_5678);
    check("restart_inst_pc", inst_pc, 32'h0);
    idleInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
